countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 91 +++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle terminal pulse.
// Define COUNTDOWN_TIMER_AUTO_RELOAD_EN to restart from the last loaded value after each terminal count.
module countdown_timer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st,
  input  logic [BUS_WIDTH-1:0] X,
  input  logic                 en,
  output logic [BUS_WIDTH-1:0] o,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [BUS_WIDTH-1:0] reload;
`endif

  // busy/done are registered alongside state so they always agree with it.
  // NOTE: non-blocking assignments for all state here; every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      o     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else if (st) begin
      o <= X;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload <= X;
`endif
      if (X != '0) begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            o <= o - 1'b1;
            if (o == BUS_WIDTH'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          o <= reload;
          if (reload != '0) begin
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          done <= 1'b0;
`else
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
